fb_pixel_writer: RTL and testbench
==================================

Name: fb_pixel_writer

Overview:
- Sits directly downstream of the pixel arbiter.
- Consumes its single-pixel write stream (valid, x, y, color) and bounds-checks each pixel against the framebuffer.
- Converts accepted pixels to linear byte addresses and buffers them in a FIFO.
- Drains the FIFO to the framebuffer memory write port through a valid/ready handshake.

Parameters:
- FB_WIDTH, 640, framebuffer width in pixels.
- FB_HEIGHT, 480, framebuffer height in pixels.
- FIFO_DEPTH, 8, write FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- fb_base  in  32  framebuffer byte base address
- pixel_valid  in  1  arbiter pixel valid
- pixel_x  in  32  pixel column, unsigned
- pixel_y  in  32  pixel row, unsigned
- pixel_color  in  32  pixel color, 0x00RRGGBB
- pixel_ready  out  1  writer can accept a pixel this cycle
- mem_wr_valid  out  1  write request valid
- mem_wr_ready  in  1  memory accepts request
- mem_wr_addr  out  32  byte address
- mem_wr_data  out  32  write data
- idle  out  1  FIFO empty
- clip_count  out  16  pixels discarded as out of bounds, saturating
- overflow  out  1  sticky: pixel_valid seen while pixel_ready low

Behaviour:
- Single clock domain: clk.
- Reset: rst_n is synchronous and active-low. Clock port is clk, reset port is rst_n.
- Reset values:
  - FIFO pointers and count = 0
  - mem_wr_valid = 0, mem_wr_addr = 0, mem_wr_data = 0
  - clip_count = 0, overflow = 0
  - idle = 1, pixel_ready = 1
- pixel_ready = !fifo_full. It is combinational from registered state only.
- Full FIFO: pixel_ready is low even if a pop occurs in the same cycle.
- Accept: pixel_valid && pixel_ready at a rising edge.
- Clip test is unsigned 32-bit: in-bounds iff pixel_x < FB_WIDTH && pixel_y < FB_HEIGHT.
- In-bounds pixel:
  - Enqueue addr = fb_base + ((pixel_y*FB_WIDTH + pixel_x) << 2), truncated mod 2^32.
  - Enqueue data = pixel_color.
  - fb_base is sampled at accept.
- Out-of-bounds pixel: accepted but not enqueued. clip_count increments and saturates at 0xFFFF.
- pixel_valid && !pixel_ready: pixel is lost and overflow is set to 1. overflow clears only on reset.
- Latency: a pixel accepted at edge N drives mem_wr_valid=1 after edge N if the FIFO was empty, i.e. a 1-cycle latency. Write-through to the memory port is in FIFO order.
- Output port presents the FIFO head:
  - mem_wr_valid = !fifo_empty.
  - Pop on mem_wr_valid && mem_wr_ready.
  - addr/data must stay stable while valid && !ready.
- Simultaneous push and pop when not full: count is unchanged and both pointers advance; pointers wrap modulo FIFO_DEPTH.
- idle = fifo_empty (registered-state derived).
- Reset mid-operation:
  - All buffered pixels are discarded.
  - mem_wr_valid drops the cycle after the reset edge.
  - Counters clear.

Optional Feature:
- Macro FB_PIXEL_WRITER_RGB565_EN.
- When defined, the framebuffer is 16bpp:
  - addr = fb_base + ((y*FB_WIDTH + x) << 1).
  - data = {16'h0000, color[23:19], color[15:10], color[7:3]}.
- When undefined: 32bpp exactly as above. No port differences.

Test Plan:
- fb_base=0x1000_0000, x=3, y=2, color=0x00FF8040, mem_wr_ready=1 -> next cycle mem_wr_valid=1, addr=0x1000_140C, data=0x00FF8040; idle returns to 1 after pop.
- x=640, y=0, valid 1 cycle -> pixel_ready stays 1, no mem_wr_valid, clip_count=1. Repeat with y=480 -> clip_count=2.
- mem_wr_ready=0, 8 consecutive in-bounds pixels -> pixel_ready=0 after 8th. 9th pixel_valid -> overflow=1. Set ready=1 -> 8 writes drained in order with addr/data stable while stalled.
- FIFO at 4 entries, simultaneous accept and pop for 20 cycles -> count stays 4, order preserved across pointer wrap.
- 5 entries buffered, rst_n=0 for 1 cycle -> mem_wr_valid=0, idle=1, clip_count=0, overflow=0 after reset edge.
- RGB565_EN defined: x=3, y=2, fb_base=0, color=0x00FF8040 -> addr=0x0000_0A06, data=0x0000_FC08.

Source files
------------

// File: rtl/fb_pixel_writer.sv
// Pixel write stream to framebuffer memory port: bounds check, linear addressing, FIFO buffering.
// Optional 16bpp RGB565 packing when FB_PIXEL_WRITER_RGB565_EN is defined.
module fb_pixel_writer #(
   parameter int unsigned FB_WIDTH   = 640,
   parameter int unsigned FB_HEIGHT  = 480,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] fb_base,
   input  logic        pixel_valid,
   input  logic [31:0] pixel_x,
   input  logic [31:0] pixel_y,
   input  logic [31:0] pixel_color,
   output logic        pixel_ready,
   output logic        mem_wr_valid,
   input  logic        mem_wr_ready,
   output logic [31:0] mem_wr_addr,
   output logic [31:0] mem_wr_data,
   output logic        idle,
   output logic [15:0] clip_count,
   output logic        overflow
);

   localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CntW = PtrW + 1;

   logic [31:0]     addr_mem [FIFO_DEPTH];
   logic [31:0]     data_mem [FIFO_DEPTH];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0] count_q;
   logic [15:0]     clip_q;
   logic            overflow_q;

   logic            fifo_full, fifo_empty;
   logic            in_bounds, accept, push, pop;
   logic [31:0]     lin_idx, push_addr, push_data;

   assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
   assign fifo_empty = (count_q == '0);

   assign in_bounds = (pixel_x < 32'(FB_WIDTH)) && (pixel_y < 32'(FB_HEIGHT));
   assign lin_idx   = pixel_y * 32'(FB_WIDTH) + pixel_x;

`ifdef FB_PIXEL_WRITER_RGB565_EN
   logic unused_color;
   assign unused_color = ^{pixel_color[31:24], pixel_color[18:16], pixel_color[9:8],
                           pixel_color[2:0]};
   assign push_addr = fb_base + (lin_idx << 1);
   assign push_data = {16'h0000, pixel_color[23:19], pixel_color[15:10], pixel_color[7:3]};
`else
   assign push_addr = fb_base + (lin_idx << 2);
   assign push_data = pixel_color;
`endif

   // A pop in the same cycle does not free a slot for a push when full.
   assign accept = pixel_valid && !fifo_full;
   assign push   = accept && in_bounds;
   assign pop    = !fifo_empty && mem_wr_ready;

   // Storage is not reset; pointers alone define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[wr_ptr_q] <= push_addr;
         data_mem[wr_ptr_q] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         clip_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push && !pop) begin
            count_q <= count_q + 1'b1;
         end else if (!push && pop) begin
            count_q <= count_q - 1'b1;
         end
         if (accept && !in_bounds && (clip_q != 16'hFFFF)) clip_q <= clip_q + 16'd1;
         if (pixel_valid && fifo_full) overflow_q <= 1'b1;
      end
   end

   assign pixel_ready  = !fifo_full;
   assign idle         = fifo_empty;
   assign mem_wr_valid = !fifo_empty;
   // Head is masked when empty so the port reads zero out of reset.
   assign mem_wr_addr  = fifo_empty ? 32'h0 : addr_mem[rd_ptr_q];
   assign mem_wr_data  = fifo_empty ? 32'h0 : data_mem[rd_ptr_q];
   assign clip_count   = clip_q;
   assign overflow     = overflow_q;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Self-checking bench for fb_pixel_writer against a queue-based reference model.
module tb_fb_pixel_writer;

   localparam int unsigned W = 640;
   localparam int unsigned H = 480;
   localparam int unsigned D = 8;
`ifdef FB_PIXEL_WRITER_RGB565_EN
   localparam int unsigned BPP     = 2;
   localparam logic [31:0] K_ADDR  = 32'h1000_0A06;
   localparam logic [31:0] K_DATA  = 32'h0000_FC08;
`else
   localparam int unsigned BPP     = 4;
   localparam logic [31:0] K_ADDR  = 32'h1000_140C;
   localparam logic [31:0] K_DATA  = 32'h00FF_8040;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] fb_base = '0;
   logic        pixel_valid = 1'b0;
   logic [31:0] pixel_x = '0, pixel_y = '0, pixel_color = '0;
   logic        pixel_ready, mem_wr_valid, idle, overflow;
   logic        mem_wr_ready = 1'b0;
   logic [31:0] mem_wr_addr, mem_wr_data;
   logic [15:0] clip_count;

   int n_cmp = 0;
   int n_bad = 0;

   logic [63:0] mq[$];
   int unsigned m_clip = 0;
   bit          m_ovf = 1'b0;

   fb_pixel_writer #(.FB_WIDTH(W), .FB_HEIGHT(H), .FIFO_DEPTH(D)) dut (
      .clk(clk), .rst_n(rst_n), .fb_base(fb_base), .pixel_valid(pixel_valid),
      .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_color(pixel_color),
      .pixel_ready(pixel_ready), .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
      .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .idle(idle),
      .clip_count(clip_count), .overflow(overflow)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_addr(logic [31:0] base, logic [31:0] x, logic [31:0] y);
      logic [31:0] idx;
      idx = y * W + x;
      return base + idx * BPP;
   endfunction

   function automatic logic [31:0] ref_data(logic [31:0] c);
`ifdef FB_PIXEL_WRITER_RGB565_EN
      return {16'h0000, c[23:19], c[15:10], c[7:3]};
`else
      return c;
`endif
   endfunction

   // Advance the model by one edge using the inputs currently applied, then step the clock.
   task automatic cycle();
      bit full, do_pop, do_push;
      full    = (mq.size() >= D);
      do_pop  = (mq.size() != 0) && mem_wr_ready;
      do_push = 1'b0;
      if (!rst_n) begin
         mq.delete();
         m_clip = 0;
         m_ovf  = 1'b0;
      end else begin
         if (pixel_valid && full) m_ovf = 1'b1;
         if (pixel_valid && !full) begin
            if (pixel_x < W && pixel_y < H) do_push = 1'b1;
            else if (m_clip < 65535) m_clip++;
         end
         if (do_pop) void'(mq.pop_front());
         if (do_push) mq.push_back({ref_addr(fb_base, pixel_x, pixel_y), ref_data(pixel_color)});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive_pixel(logic [31:0] x, logic [31:0] y, logic [31:0] c);
      pixel_valid = 1'b1;
      pixel_x = x;
      pixel_y = y;
      pixel_color = c;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      cycle();
      cycle();
      rst_n = 1'b1;
      n_cmp += 7;
      if (pixel_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", pixel_ready); end
      if (mem_wr_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", mem_wr_valid); end
      if (mem_wr_addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", mem_wr_addr); end
      if (mem_wr_data !== 32'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0", mem_wr_data); end
      if (idle !== 1'b1) begin n_bad++; $display("FAIL reset_idle: got %b want 1", idle); end
      if (clip_count !== 16'h0) begin n_bad++; $display("FAIL reset_clip: got %h want 0", clip_count); end
      if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", overflow); end
   endtask

   task automatic test_single();
      fb_base = 32'h1000_0000;
      mem_wr_ready = 1'b1;
      drive_pixel(32'd3, 32'd2, 32'h00FF_8040);
      cycle();
      pixel_valid = 1'b0;
      n_cmp += 5;
      if (mem_wr_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %b want 1", mem_wr_valid); end
      if (mem_wr_addr !== K_ADDR) begin n_bad++; $display("FAIL single_addr: got %h want %h", mem_wr_addr, K_ADDR); end
      if (mem_wr_data !== K_DATA) begin n_bad++; $display("FAIL single_data: got %h want %h", mem_wr_data, K_DATA); end
      if (idle !== 1'b0) begin n_bad++; $display("FAIL single_busy: got %b want 0", idle); end
      cycle();
      if (idle !== 1'b1) begin n_bad++; $display("FAIL single_idle: got %b want 1", idle); end
   endtask

   task automatic test_clip();
      mem_wr_ready = 1'b1;
      drive_pixel(W, 32'd0, 32'h0012_3456);
      cycle();
      pixel_valid = 1'b0;
      n_cmp += 6;
      if (pixel_ready !== 1'b1) begin n_bad++; $display("FAIL clip_ready: got %b want 1", pixel_ready); end
      if (mem_wr_valid !== 1'b0) begin n_bad++; $display("FAIL clip_valid: got %b want 0", mem_wr_valid); end
      if (clip_count !== 16'd1) begin n_bad++; $display("FAIL clip_one: got %0d want 1", clip_count); end
      drive_pixel(32'd0, H, 32'h0012_3456);
      cycle();
      pixel_valid = 1'b0;
      if (pixel_ready !== 1'b1) begin n_bad++; $display("FAIL clip2_ready: got %b want 1", pixel_ready); end
      if (mem_wr_valid !== 1'b0) begin n_bad++; $display("FAIL clip2_valid: got %b want 0", mem_wr_valid); end
      if (clip_count !== 16'd2) begin n_bad++; $display("FAIL clip_two: got %0d want 2", clip_count); end
   endtask

   task automatic test_backpressure();
      int guard;
      mem_wr_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         fb_base = $urandom;
         drive_pixel($urandom_range(0, W - 1), $urandom_range(0, H - 1), $urandom);
         cycle();
      end
      n_cmp += 3;
      if (pixel_ready !== 1'b0) begin n_bad++; $display("FAIL bp_full: got %b want 0", pixel_ready); end
      if (overflow !== 1'b0) begin n_bad++; $display("FAIL bp_noovf: got %b want 0", overflow); end
      drive_pixel(32'd1, 32'd1, 32'hDEAD_BEEF);
      cycle();
      pixel_valid = 1'b0;
      if (overflow !== 1'b1) begin n_bad++; $display("FAIL bp_ovf: got %b want 1", overflow); end
      guard = 0;
      while (mq.size() != 0 && guard < 200) begin
         n_cmp++;
         if (mem_wr_valid !== 1'b1 || {mem_wr_addr, mem_wr_data} !== mq[0]) begin
            n_bad++;
            $display("FAIL bp_head: got %b %h %h want 1 %h", mem_wr_valid, mem_wr_addr, mem_wr_data, mq[0]);
         end
         mem_wr_ready = ($urandom_range(0, 2) != 0);
         cycle();
         guard++;
      end
      n_cmp += 2;
      if (guard >= 200) begin n_bad++; $display("FAIL bp_drain_timeout: got %0d left want 0", mq.size()); end
      if (idle !== 1'b1) begin n_bad++; $display("FAIL bp_idle: got %b want 1", idle); end
   endtask

   task automatic test_wrap();
      mem_wr_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive_pixel($urandom_range(0, W - 1), $urandom_range(0, H - 1), $urandom);
         cycle();
      end
      mem_wr_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         n_cmp++;
         if ({mem_wr_addr, mem_wr_data} !== mq[0]) begin
            n_bad++;
            $display("FAIL wrap_head%0d: got %h %h want %h", i, mem_wr_addr, mem_wr_data, mq[0]);
         end
         fb_base = $urandom;
         drive_pixel($urandom_range(0, W - 1), $urandom_range(0, H - 1), $urandom);
         cycle();
         n_cmp += 2;
         if (pixel_ready !== 1'b1) begin n_bad++; $display("FAIL wrap_ready%0d: got %b want 1", i, pixel_ready); end
         if (mq.size() != 4) begin n_bad++; $display("FAIL wrap_count%0d: got %0d want 4", i, mq.size()); end
      end
      pixel_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (mem_wr_valid !== 1'b1 || {mem_wr_addr, mem_wr_data} !== mq[0]) begin
            n_bad++;
            $display("FAIL wrap_drain%0d: got %b %h %h want 1 %h", i, mem_wr_valid, mem_wr_addr, mem_wr_data, mq[0]);
         end
         cycle();
      end
      n_cmp++;
      if (idle !== 1'b1) begin n_bad++; $display("FAIL wrap_idle: got %b want 1", idle); end
   endtask

   task automatic test_random();
      bit ev;
      for (int i = 0; i < 500; i++) begin
         fb_base = $urandom;
         pixel_valid = ($urandom_range(0, 9) < 7);
         case ($urandom_range(0, 3))
            0, 1: pixel_x = $urandom_range(0, W - 1);
            2: pixel_x = W + $urandom_range(0, 2) - 1;
            default: pixel_x = $urandom;
         endcase
         case ($urandom_range(0, 3))
            0, 1: pixel_y = $urandom_range(0, H - 1);
            2: pixel_y = H + $urandom_range(0, 2) - 1;
            default: pixel_y = $urandom;
         endcase
         pixel_color = $urandom;
         mem_wr_ready = ($urandom_range(0, 1) == 1);
         cycle();
         ev = (mq.size() != 0);
         n_cmp += 6;
         if (mem_wr_valid !== ev) begin n_bad++; $display("FAIL rnd_valid%0d: got %b want %b", i, mem_wr_valid, ev); end
         if (ev && {mem_wr_addr, mem_wr_data} !== mq[0]) begin
            n_bad++;
            $display("FAIL rnd_head%0d: got %h %h want %h", i, mem_wr_addr, mem_wr_data, mq[0]);
         end
         if (pixel_ready !== (mq.size() < D)) begin n_bad++; $display("FAIL rnd_ready%0d: got %b", i, pixel_ready); end
         if (idle !== !ev) begin n_bad++; $display("FAIL rnd_idle%0d: got %b want %b", i, idle, !ev); end
         if (clip_count !== 16'(m_clip)) begin n_bad++; $display("FAIL rnd_clip%0d: got %0d want %0d", i, clip_count, m_clip); end
         if (overflow !== m_ovf) begin n_bad++; $display("FAIL rnd_ovf%0d: got %b want %b", i, overflow, m_ovf); end
      end
      pixel_valid = 1'b0;
   endtask

   task automatic test_saturate();
      mem_wr_ready = 1'b1;
      drive_pixel(W, H, 32'h0);
      for (int i = 0; i < 65600; i++) cycle();
      pixel_valid = 1'b0;
      n_cmp += 2;
      if (clip_count !== 16'hFFFF) begin n_bad++; $display("FAIL sat_clip: got %h want ffff", clip_count); end
      if (mem_wr_valid !== 1'b0) begin n_bad++; $display("FAIL sat_valid: got %b want 0", mem_wr_valid); end
   endtask

   task automatic test_reset_mid();
      mem_wr_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive_pixel($urandom_range(0, W - 1), $urandom_range(0, H - 1), $urandom);
         cycle();
      end
      pixel_valid = 1'b0;
      n_cmp++;
      if (mem_wr_valid !== 1'b1) begin n_bad++; $display("FAIL mid_prefill: got %b want 1", mem_wr_valid); end
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      n_cmp += 5;
      if (mem_wr_valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid: got %b want 0", mem_wr_valid); end
      if (idle !== 1'b1) begin n_bad++; $display("FAIL mid_idle: got %b want 1", idle); end
      if (clip_count !== 16'h0) begin n_bad++; $display("FAIL mid_clip: got %h want 0", clip_count); end
      if (overflow !== 1'b0) begin n_bad++; $display("FAIL mid_ovf: got %b want 0", overflow); end
      if (pixel_ready !== 1'b1) begin n_bad++; $display("FAIL mid_ready: got %b want 1", pixel_ready); end
   endtask

   initial begin
      #2;
      test_reset();
      test_single();
      test_clip();
      test_backpressure();
      test_wrap();
      test_random();
      test_saturate();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
